projection_mask_painter: RTL and testbench
==========================================

# projection_mask_painter

Write-side engine for the 4-bit projection mask buffer that the VGA output stage reads back as a per-pixel label and maps through its colour palette (label 0 = transparent, camera pixel shown). It accepts rectangle-fill commands and frame-clear requests and streams one label write per cycle into the mask BRAM's write port. It sits between the AR control logic and the mask frame buffer.

## Interface
- MASK_W, default 320: mask width in pixels.
- MASK_H, default 240: mask height in pixels.
- ADDR_W, default $clog2(MASK_W*MASK_H) = 17: write address width.
- clk_in  input  1  system clock; single clock domain.
- rst_in  input  1  asynchronous, active-low reset.
- clear_in  input  1  one-cycle request to write label 0 to the whole mask.
- cmd_valid_in  input  1  rectangle command valid.
- cmd_ready_out  output  1  high only in IDLE with no pending clear.
- cmd_x0_in, cmd_x1_in  input  9  inclusive column bounds.
- cmd_y0_in, cmd_y1_in  input  8  inclusive row bounds.
- cmd_label_in  input  4  label to paint (0 erases).
- mask_we_out  output  1  write strobe to mask BRAM.
- mask_addr_out  output  ADDR_W  write address, row-major, y*MASK_W + x.
- mask_data_out  output  4  write data.
- busy_out  output  1  high in CLEAR or FILL.
- done_out  output  1  one-cycle pulse after the last write of a clear or fill.
- err_out  output  1  one-cycle pulse when a command is rejected.

## Operation
- States: IDLE, CLEAR, FILL. Reset enters IDLE; all outputs 0 except cmd_ready_out, which is 1 once reset deasserts with no clear pending.
- clear_in is latched into a pending flag in any state; serviced on the next IDLE cycle. Pending clear has priority over a command in the same cycle; cmd_ready_out is low while the flag is set.
- IDLE, pending clear: go CLEAR, addr = 0. CLEAR writes data 0 at addr 0..MASK_W*MASK_H-1, one per cycle, then IDLE with done_out.
- IDLE, cmd_valid_in & cmd_ready_out: command accepted, fields registered. Rejected (err_out pulse, stay IDLE, no writes) if x0>x1 or y0>y1, or out of range per Configuration.
- FILL: x counter x0..x1, y counter y0..y1, write address incremented by 1 along a row; at row end address += MASK_W-(x1-x0). Start address y0*MASK_W+x0 computed at accept (constant multiply). After writing (x1,y1): IDLE with done_out.
- Total FILL writes = (x1-x0+1)*(y1-y0+1); mask_data_out = registered label throughout.
- Mid-operation reset: immediate return to IDLE, writes stop, pending clear dropped; partial mask content is not repaired.

## Timing
- Command accepted at edge N: first write (mask_we_out=1) visible in cycle N+1; last write in cycle N+count; done_out in cycle N+count+1, cmd_ready_out high that same cycle (back-to-back command accepted there).
- Clear takes exactly MASK_W*MASK_H write cycles (76800 at defaults).
- err_out asserted the cycle after the rejected handshake; cmd_ready_out stays high.
- All outputs registered; no combinational path from inputs to outputs except none (cmd_ready_out is registered state).

## Configuration
- MASK_PAINTER_CLIP_EN defined: x1 clamped to MASK_W-1 and y1 to MASK_H-1 at accept; a command whose x0>=MASK_W or y0>=MASK_H is rejected.
- Not defined: any coordinate >= MASK_W / MASK_H rejects the whole command with err_out.

## Structure
- Package mask_pkg: MASK_W, MASK_H, MASK_DEPTH, label_t (logic [3:0]), LABEL_CLEAR = 0, painter_state_t enum; shared with the mask buffer and VGA read path.
- One sub-module natural: mask_raster_counter (x/y counters, address stepping, last-pixel flag), reused by CLEAR as a full-frame raster.

## Test plan
- Reset then clear_in pulse -> 76800 writes, addresses 0..76799, data 0, single done_out, busy_out low after.
- Command (10,5)-(12,6), label 3 -> 6 writes at 1610,1611,1612,1930,1931,1932, data 3, done_out in cycle N+7.
- Command x0=20,x1=19 -> no writes, err_out one cycle, cmd_ready_out stays 1.
- Command (300,230)-(400,250): with MASK_PAINTER_CLIP_EN -> 20*10=200 writes ending at 76799; without -> err_out, no writes.
- clear_in and cmd_valid_in same cycle in IDLE -> clear runs first, command accepted at clear's done cycle; clear_in during FILL -> clear starts after fill's done.
- rst_in low mid-FILL -> mask_we_out 0 next cycle, IDLE, ready high after release, no done_out.

Source files
------------

// File: rtl/mask_pkg.sv
// Shared mask buffer definitions: geometry, label type and painter states.
// Imported by the painter, the mask buffer and the VGA read path.
package mask_pkg;

  localparam int MASK_W     = 320;
  localparam int MASK_H     = 240;
  localparam int MASK_DEPTH = MASK_W * MASK_H;

  localparam int X_W = 9;
  localparam int Y_W = 8;

  typedef logic [3:0] label_t;

  localparam label_t LABEL_CLEAR = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_FILL  = 2'd2
  } painter_state_t;

  function automatic int row_major(
    input int x,
    input int y,
    input int w
  );
    return y * w + x;
  endfunction

endpackage

// File: rtl/mask_raster_counter.sv
// Rectangle raster walker: x/y counters, row-major address stepping
// and last-pixel flag. A full-frame load gives the clear sweep.
module mask_raster_counter
  import mask_pkg::*;
#(
  parameter int W      = MASK_W,
  parameter int ADDR_W = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              load_in,
  input  logic              step_in,
  input  logic [X_W-1:0]    x0_in,
  input  logic [X_W-1:0]    x1_in,
  input  logic [Y_W-1:0]    y0_in,
  input  logic [Y_W-1:0]    y1_in,
  input  logic [ADDR_W-1:0] addr0_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              last_out
);

  logic [X_W-1:0]    r_x;
  logic [X_W-1:0]    r_x0;
  logic [X_W-1:0]    r_x1;
  logic [Y_W-1:0]    r_y;
  logic [Y_W-1:0]    r_y1;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_row_step;
  logic              w_row_end;

  assign w_row_end = (r_x == r_x1);
  assign last_out  = w_row_end && (r_y == r_y1);
  assign addr_out  = r_addr;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_x        <= '0;
      r_x0       <= '0;
      r_x1       <= '0;
      r_y        <= '0;
      r_y1       <= '0;
      r_addr     <= '0;
      r_row_step <= '0;
    end else if (load_in) begin
      r_x        <= x0_in;
      r_x0       <= x0_in;
      r_x1       <= x1_in;
      r_y        <= y0_in;
      r_y1       <= y1_in;
      r_addr     <= addr0_in;
      // jump from (x1,y) to (x0,y+1)
      r_row_step <= ADDR_W'(W - int'(x1_in) + int'(x0_in));
    end else if (step_in) begin
      if (w_row_end) begin
        r_x    <= r_x0;
        r_y    <= r_y + Y_W'(1);
        r_addr <= r_addr + r_row_step;
      end else begin
        r_x    <= r_x + X_W'(1);
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/projection_mask_painter.sv
// Rectangle-fill / frame-clear write engine for the 4-bit mask buffer.
// Define MASK_PAINTER_CLIP_EN to clamp oversize rectangles to the mask.
module projection_mask_painter #(
  parameter int MASK_W = mask_pkg::MASK_W,
  parameter int MASK_H = mask_pkg::MASK_H,
  parameter int ADDR_W = $clog2(MASK_W * MASK_H)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              clear_in,
  input  logic              cmd_valid_in,
  output logic              cmd_ready_out,
  input  logic [8:0]        cmd_x0_in,
  input  logic [8:0]        cmd_x1_in,
  input  logic [7:0]        cmd_y0_in,
  input  logic [7:0]        cmd_y1_in,
  input  logic [3:0]        cmd_label_in,
  output logic              mask_we_out,
  output logic [ADDR_W-1:0] mask_addr_out,
  output logic [3:0]        mask_data_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out
);

  import mask_pkg::*;

  localparam int XMAX = MASK_W - 1;
  localparam int YMAX = MASK_H - 1;

  painter_state_t    r_state;
  painter_state_t    w_state_nx;
  logic              r_clr_pend;
  logic              w_clr_pend_nx;
  label_t            r_label;
  label_t            w_label_nx;
  logic              r_ready;
  logic              r_busy;
  logic              r_we;
  logic              r_done;
  logic              r_err;
  logic              w_ready_nx;
  logic              w_busy_nx;
  logic              w_done_nx;
  logic              w_err_nx;

  logic              w_go_clear;
  logic              w_hs;
  logic              w_bad_order;
  logic              w_bad_range;
  logic              w_accept;
  logic              w_reject;
  logic [X_W-1:0]    w_x1;
  logic [Y_W-1:0]    w_y1;
  logic [ADDR_W-1:0] w_addr0;

  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic [X_W-1:0]    w_ld_x0;
  logic [X_W-1:0]    w_ld_x1;
  logic [Y_W-1:0]    w_ld_y0;
  logic [Y_W-1:0]    w_ld_y1;
  logic [ADDR_W-1:0] w_ld_addr;
  logic [ADDR_W-1:0] w_addr;

  assign w_bad_order = (cmd_x0_in > cmd_x1_in) ||
                       (cmd_y0_in > cmd_y1_in);

`ifdef MASK_PAINTER_CLIP_EN
  assign w_bad_range = (int'(cmd_x0_in) > XMAX) ||
                       (int'(cmd_y0_in) > YMAX);
  assign w_x1 = (int'(cmd_x1_in) > XMAX) ?
                X_W'(XMAX) : cmd_x1_in;
  assign w_y1 = (int'(cmd_y1_in) > YMAX) ?
                Y_W'(YMAX) : cmd_y1_in;
`else
  assign w_bad_range = (int'(cmd_x0_in) > XMAX) ||
                       (int'(cmd_x1_in) > XMAX) ||
                       (int'(cmd_y0_in) > YMAX) ||
                       (int'(cmd_y1_in) > YMAX);
  assign w_x1 = cmd_x1_in;
  assign w_y1 = cmd_y1_in;
`endif

  assign w_addr0 = ADDR_W'(row_major(int'(cmd_x0_in),
                                     int'(cmd_y0_in),
                                     MASK_W));

  // a clear request in the same cycle wins over the command
  assign w_go_clear = (r_state == ST_IDLE) &&
                      (r_clr_pend || clear_in);
  assign w_hs       = r_ready && cmd_valid_in &&
                      !r_clr_pend && !clear_in;
  assign w_accept   = w_hs && !w_bad_order && !w_bad_range;
  assign w_reject   = w_hs && (w_bad_order || w_bad_range);

  always_comb begin
    w_state_nx = r_state;
    w_label_nx = r_label;
    w_load     = 1'b0;
    w_step     = 1'b0;
    w_done_nx  = 1'b0;
    w_err_nx   = 1'b0;
    w_ld_x0    = cmd_x0_in;
    w_ld_x1    = w_x1;
    w_ld_y0    = cmd_y0_in;
    w_ld_y1    = w_y1;
    w_ld_addr  = w_addr0;
    unique case (r_state)
      ST_IDLE: begin
        unique case (1'b1)
          w_go_clear: begin
            w_state_nx = ST_CLEAR;
            w_label_nx = LABEL_CLEAR;
            w_load     = 1'b1;
            w_ld_x0    = '0;
            w_ld_x1    = X_W'(XMAX);
            w_ld_y0    = '0;
            w_ld_y1    = Y_W'(YMAX);
            w_ld_addr  = '0;
          end
          w_accept: begin
            w_state_nx = ST_FILL;
            w_label_nx = cmd_label_in;
            w_load     = 1'b1;
          end
          w_reject: begin
            w_err_nx = 1'b1;
          end
          default: ;
        endcase
      end
      ST_CLEAR, ST_FILL: begin
        if (w_last) begin
          w_state_nx = ST_IDLE;
          w_done_nx  = 1'b1;
        end else begin
          w_step = 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    w_clr_pend_nx = (r_clr_pend || clear_in) && !w_go_clear;
    w_busy_nx     = (w_state_nx != ST_IDLE);
    w_ready_nx    = (w_state_nx == ST_IDLE) && !w_clr_pend_nx;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= ST_IDLE;
      r_clr_pend <= 1'b0;
      r_label    <= LABEL_CLEAR;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_clr_pend <= w_clr_pend_nx;
      r_label    <= w_label_nx;
      r_ready    <= w_ready_nx;
      r_busy     <= w_busy_nx;
      r_we       <= w_busy_nx;
      r_done     <= w_done_nx;
      r_err      <= w_err_nx;
    end
  end

  mask_raster_counter #(
    .W      (MASK_W),
    .ADDR_W (ADDR_W)
  ) u_raster (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .load_in  (w_load),
    .step_in  (w_step),
    .x0_in    (w_ld_x0),
    .x1_in    (w_ld_x1),
    .y0_in    (w_ld_y0),
    .y1_in    (w_ld_y1),
    .addr0_in (w_ld_addr),
    .addr_out (w_addr),
    .last_out (w_last)
  );

  assign cmd_ready_out = r_ready;
  assign mask_we_out   = r_we;
  assign mask_addr_out = w_addr;
  assign mask_data_out = r_label;
  assign busy_out      = r_busy;
  assign done_out      = r_done;
  assign err_out       = r_err;

endmodule

// File: tb/tb_projection_mask_painter.sv
// Bench for projection_mask_painter: directed and random rectangles
// against a row-major reference model, plus clear and reset scenarios.
module tb_projection_mask_painter;

  localparam int W     = 320;
  localparam int H     = 240;
  localparam int DEPTH = W * H;
  localparam int AW    = 17;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          clear_in;
  logic          cmd_valid_in;
  logic          cmd_ready_out;
  logic [8:0]    cmd_x0_in;
  logic [8:0]    cmd_x1_in;
  logic [7:0]    cmd_y0_in;
  logic [7:0]    cmd_y1_in;
  logic [3:0]    cmd_label_in;
  logic          mask_we_out;
  logic [AW-1:0] mask_addr_out;
  logic [3:0]    mask_data_out;
  logic          busy_out;
  logic          done_out;
  logic          err_out;

  projection_mask_painter dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .clear_in      (clear_in),
    .cmd_valid_in  (cmd_valid_in),
    .cmd_ready_out (cmd_ready_out),
    .cmd_x0_in     (cmd_x0_in),
    .cmd_x1_in     (cmd_x1_in),
    .cmd_y0_in     (cmd_y0_in),
    .cmd_y1_in     (cmd_y1_in),
    .cmd_label_in  (cmd_label_in),
    .mask_we_out   (mask_we_out),
    .mask_addr_out (mask_addr_out),
    .mask_data_out (mask_data_out),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .err_out       (err_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  int wq_addr[$];
  int wq_data[$];
  int wq_cyc[$];
  int dq_cyc[$];
  int dq_rdy[$];
  int eq_cyc[$];
  int eq_rdy[$];
  int exp_q[$];

  always @(negedge clk_in) begin
    if (mask_we_out === 1'b1) begin
      wq_addr.push_back(int'(mask_addr_out));
      wq_data.push_back(int'(mask_data_out));
      wq_cyc.push_back(cyc);
    end
    if (done_out === 1'b1) begin
      dq_cyc.push_back(cyc);
      dq_rdy.push_back(int'(cmd_ready_out));
    end
    if (err_out === 1'b1) begin
      eq_cyc.push_back(cyc);
      eq_rdy.push_back(int'(cmd_ready_out));
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_in);
    #1;
  endtask

  task automatic flush();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    dq_cyc.delete();
    dq_rdy.delete();
    eq_cyc.delete();
    eq_rdy.delete();
  endtask

  // expected write addresses, straight from the rectangle rules
  function automatic bit model(input int x0, input int x1,
                               input int y0, input int y1);
    bit rej;
    exp_q.delete();
    rej = (x0 > x1) || (y0 > y1);
`ifdef MASK_PAINTER_CLIP_EN
    if (x0 >= W || y0 >= H) rej = 1'b1;
    if (x1 >= W) x1 = W - 1;
    if (y1 >= H) y1 = H - 1;
`else
    if (x0 >= W || x1 >= W || y0 >= H || y1 >= H) rej = 1'b1;
`endif
    if (!rej)
      for (int y = y0; y <= y1; y++)
        for (int x = x0; x <= x1; x++)
          exp_q.push_back(y * W + x);
    return rej;
  endfunction

  task automatic wait_ready(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++)
      if (cmd_ready_out === 1'b1) ok = 1'b1;
      else step();
    chk({tag, " ready"}, 32'(ok), 1);
  endtask

  task automatic drive(input int x0, input int x1,
                       input int y0, input int y1, input int lab);
    cmd_x0_in    = 9'(x0);
    cmd_x1_in    = 9'(x1);
    cmd_y0_in    = 8'(y0);
    cmd_y1_in    = 8'(y1);
    cmd_label_in = 4'(lab);
    cmd_valid_in = 1'b1;
  endtask

  task automatic rect(input string tag, input int x0, input int x1,
                      input int y0, input int y1, input int lab);
    bit rej;
    bit ok;
    int acc;
    int n;
    int mism;
    rej = model(x0, x1, y0, y1);
    n   = exp_q.size();
    flush();
    wait_ready(tag);
    drive(x0, x1, y0, y1, lab);
    acc = cyc + 1;
    step();
    cmd_valid_in = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < n + 20 && !ok; i++)
      if (done_out === 1'b1 || err_out === 1'b1) ok = 1'b1;
      else step();
    chk({tag, " end"}, 32'(ok), 1);
    chk({tag, " nwr"}, wq_addr.size(), n);
    mism = 0;
    for (int i = 0; i < wq_addr.size() && i < n; i++)
      if (wq_addr[i] != exp_q[i] || wq_data[i] != lab) mism++;
    chk({tag, " wdata"}, mism, 0);
    chk({tag, " ndone"}, dq_cyc.size(), rej ? 0 : 1);
    chk({tag, " nerr"}, eq_cyc.size(), rej ? 1 : 0);
    if (!rej && wq_cyc.size() > 0 && dq_cyc.size() > 0) begin
      chk({tag, " first"}, wq_cyc[0], acc);
      chk({tag, " donecyc"}, dq_cyc[0], acc + n);
      chk({tag, " donerdy"}, dq_rdy[0], 1);
    end
    if (rej && eq_cyc.size() > 0) begin
      chk({tag, " errcyc"}, eq_cyc[0], acc);
      chk({tag, " errrdy"}, eq_rdy[0], 1);
    end
    step();
    chk({tag, " idle"}, busy_out, 0);
  endtask

  initial begin
    bit ok;
    int acc;
    int n;
    int mism;
    int fd;

    rst_in       = 1'b0;
    clear_in     = 1'b0;
    cmd_valid_in = 1'b0;
    cmd_x0_in    = '0;
    cmd_x1_in    = '0;
    cmd_y0_in    = '0;
    cmd_y1_in    = '0;
    cmd_label_in = '0;
    repeat (3) step();
    chk("rst we", mask_we_out, 0);
    chk("rst busy", busy_out, 0);
    chk("rst done", done_out, 0);
    chk("rst err", err_out, 0);
    chk("rst ready", cmd_ready_out, 0);
    rst_in = 1'b1;
    step();
    step();
    chk("post-rst ready", cmd_ready_out, 1);

    // clear and command in the same cycle: clear first
    flush();
    void'(model(10, 12, 5, 6));
    n = exp_q.size();
    drive(10, 12, 5, 6, 3);
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < DEPTH + 50 && !ok; i++)
      if (done_out === 1'b1 && cmd_ready_out === 1'b1) ok = 1'b1;
      else step();
    chk("clr end", 32'(ok), 1);
    acc = cyc + 1;
    step();
    cmd_valid_in = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++)
      if (done_out === 1'b1) ok = 1'b1;
      else step();
    chk("clr cmd end", 32'(ok), 1);
    chk("clr nwr", wq_addr.size(), DEPTH + n);
    mism = 0;
    for (int i = 0; i < DEPTH && i < wq_addr.size(); i++)
      if (wq_addr[i] != i || wq_data[i] != 0) mism++;
    chk("clr sweep", mism, 0);
    mism = 0;
    for (int i = 0; i < n && DEPTH + i < wq_addr.size(); i++)
      if (wq_addr[DEPTH+i] != exp_q[i] || wq_data[DEPTH+i] != 3)
        mism++;
    chk("clr cmd wdata", mism, 0);
    chk("clr ndone", dq_cyc.size(), 2);
    if (dq_cyc.size() == 2 && wq_cyc.size() == DEPTH + n) begin
      chk("clr donecyc", dq_cyc[0], wq_cyc[DEPTH-1] + 1);
      chk("clr cmd acc", wq_cyc[DEPTH], acc);
      chk("clr cmd first", wq_cyc[DEPTH], dq_cyc[0] + 1);
      chk("clr cmd done", dq_cyc[1], dq_cyc[0] + 1 + n);
    end
    step();
    chk("clr busy", busy_out, 0);

    rect("r1", 10, 12, 5, 6, 3);
    rect("xswap", 20, 19, 0, 0, 7);
    rect("yswap", 0, 0, 9, 8, 7);
    rect("edge", 300, 400, 230, 250, 6);
    rect("corner", 319, 319, 239, 239, 15);
    rect("erase", 0, 2, 0, 1, 0);

    for (int k = 0; k < 25; k++) begin
      int x0;
      int x1;
      int y0;
      int y1;
      int t;
      x0 = $urandom_range(0, W + 5);
      x1 = x0 + $urandom_range(0, 6);
      y0 = $urandom_range(0, H + 3);
      y1 = y0 + $urandom_range(0, 5);
      if ($urandom_range(0, 7) == 0) begin
        t  = x0;
        x0 = x1;
        x1 = t;
      end
      rect("rnd", x0, x1, y0, y1, $urandom_range(0, 15));
    end

    // clear requested mid-fill runs after the fill's done
    flush();
    void'(model(0, 39, 0, 1));
    n = exp_q.size();
    wait_ready("cdf");
    drive(0, 39, 0, 1, 5);
    step();
    cmd_valid_in = 1'b0;
    repeat (10) step();
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++)
      if (done_out === 1'b1) ok = 1'b1;
      else step();
    chk("cdf end", 32'(ok), 1);
    chk("cdf ready", cmd_ready_out, 0);
    fd = cyc;
    repeat (20) step();
    chk("cdf busy", busy_out, 1);
    chk("cdf nwr", wq_addr.size(), n + 20);
    mism = 0;
    for (int i = 0; i < wq_addr.size(); i++)
      if (i < n) begin
        if (wq_addr[i] != exp_q[i] || wq_data[i] != 5) mism++;
      end else begin
        if (wq_addr[i] != i - n || wq_data[i] != 0) mism++;
      end
    chk("cdf wdata", mism, 0);
    if (wq_cyc.size() > n)
      chk("cdf clr start", wq_cyc[n], fd + 1);
    chk("cdf ndone", dq_cyc.size(), 1);
    rst_in = 1'b0;
    step();
    rst_in = 1'b1;
    step();
    step();

    // reset in the middle of a fill
    flush();
    wait_ready("rmf");
    drive(0, 99, 0, 9, 9);
    step();
    cmd_valid_in = 1'b0;
    repeat (50) step();
    chk("rmf busy pre", busy_out, 1);
    rst_in = 1'b0;
    #1;
    chk("rmf we now", mask_we_out, 0);
    step();
    chk("rmf we", mask_we_out, 0);
    chk("rmf busy", busy_out, 0);
    rst_in = 1'b1;
    step();
    step();
    chk("rmf ready", cmd_ready_out, 1);
    chk("rmf ndone", dq_cyc.size(), 0);
    chk("rmf partial", 32'(wq_addr.size() > 0 &&
                          wq_addr.size() < 1000), 1);
    rect("post", 5, 6, 0, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
